// File: rtl/multi_channel_output_driver_pkg.sv
// -----------------------------------------------------------------------------
// multi_channel_output_driver_pkg
// Shared definitions for the multi-channel tooth-scheduled output driver:
//   - per-channel state encoding
//   - default tooth index and delay timer widths
//   - helper that returns the LSB position of a channel's slice in a packed bus
// -----------------------------------------------------------------------------
package multi_channel_output_driver_pkg;

  localparam int DEF_TOOTH_W = 8;
  localparam int DEF_TIMER_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_WAIT_END_TOOTH = 2'd1,
    ST_WAIT_EXPIRY    = 2'd2
  } ch_state_e;

  // Channel idx of a packed bus occupies [slice_lsb(idx, width) +: width].
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/multi_channel_output_driver_channel.sv
// -----------------------------------------------------------------------------
// output_driver_channel
// One output channel: arms on a start-tooth match, runs a start delay and an
// end delay (the end delay is triggered by the end-tooth match, or by the start
// match itself when both teeth are equal), drives the output with the
// configured polarity and pulses done on return to IDLE.
//
// Optional feature (macro MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN):
//   on-time counter; reaching MAX_ON_COUNTS active cycles forces the output
//   inactive, returns to IDLE, pulses done and sets the sticky fault flag.
//   Without the macro fault is tied low and MAX_ON_COUNTS is ignored.
//
// Ports:
//   clk            system clock
//   i_reset        synchronous active-high reset (also clears fault)
//   i_tooth_num    current tooth index
//   i_tooth_edge   one-cycle strobe, i_tooth_num valid
//   i_sync_lost    level; aborts the event without a done pulse
//   i_en           arm enable, sampled only in IDLE
//   i_start_tooth  tooth that arms the channel
//   i_end_tooth    tooth that starts the end delay
//   i_start_counts cycles from start match to output active (minus one)
//   i_end_counts   cycles from end trigger to output inactive (minus one)
//   o_out          channel output, active level = ~OUT_INVERT
//   o_busy         channel not IDLE
//   o_done         one-cycle pulse on completed or cancelled event
//   o_fault        sticky overdwell flag
// -----------------------------------------------------------------------------
module output_driver_channel
  import multi_channel_output_driver_pkg::*;
#(
  parameter int                 TOOTH_W       = DEF_TOOTH_W,
  parameter int                 TIMER_W       = DEF_TIMER_W,
  parameter bit                 OUT_INVERT    = 1'b0,
  parameter logic [TIMER_W-1:0] MAX_ON_COUNTS = {TIMER_W{1'b1}}
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [TOOTH_W-1:0] i_tooth_num,
  input  logic               i_tooth_edge,
  input  logic               i_sync_lost,
  input  logic               i_en,
  input  logic [TOOTH_W-1:0] i_start_tooth,
  input  logic [TOOTH_W-1:0] i_end_tooth,
  input  logic [TIMER_W-1:0] i_start_counts,
  input  logic [TIMER_W-1:0] i_end_counts,
  output logic               o_out,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fault
);

  ch_state_e          r_state, w_state_nxt;
  logic [TIMER_W-1:0] r_start_cnt, w_start_cnt_nxt;
  logic [TIMER_W-1:0] r_end_cnt, w_end_cnt_nxt;
  logic               r_start_pend, w_start_pend_nxt;
  logic               r_end_run, w_end_run_nxt;
  logic               r_active, w_active_nxt;
  logic               r_done, w_done_nxt;
  logic [TOOTH_W-1:0] r_end_tooth, w_end_tooth_nxt;

  logic               w_arm;
  logic               w_end_match;
  logic               w_fire_start;
  logic               w_fire_end;

`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
  localparam logic [TIMER_W-1:0] ON_LIMIT = MAX_ON_COUNTS - 1'b1;
  logic [TIMER_W-1:0] r_on_cnt, w_on_cnt_nxt;
  logic               r_fault, w_fault_nxt;
`else
  logic               w_unused_max;
  assign w_unused_max = ^MAX_ON_COUNTS;
`endif

  // Arming is blocked during the done cycle so a new event starts no earlier
  // than the cycle after the pulse.
  assign w_arm       = (r_state == ST_IDLE) && !r_done && i_en && i_tooth_edge &&
                       (i_tooth_num == i_start_tooth);
  assign w_end_match = (r_state == ST_WAIT_END_TOOTH) && i_tooth_edge &&
                       (i_tooth_num == r_end_tooth);

  always_comb begin
    w_state_nxt      = r_state;
    w_start_cnt_nxt  = r_start_cnt;
    w_start_pend_nxt = r_start_pend;
    w_end_cnt_nxt    = r_end_cnt;
    w_end_run_nxt    = r_end_run;
    w_active_nxt     = r_active;
    w_done_nxt       = 1'b0;
    w_end_tooth_nxt  = r_end_tooth;
    w_fire_start     = 1'b0;
    w_fire_end       = 1'b0;
`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
    w_on_cnt_nxt     = '0;
    w_fault_nxt      = r_fault;
`endif

    // Counters hold "cycles still to wait after this edge"; a zero count
    // fires on the edge that sees it, so a programmed delay of N lands the
    // output change N+1 cycles after the triggering tooth.
    if (r_start_pend) begin
      if (r_start_cnt == '0) w_fire_start = 1'b1;
      else                   w_start_cnt_nxt = r_start_cnt - 1'b1;
    end
    if (r_end_run) begin
      if (r_end_cnt == '0) w_fire_end = 1'b1;
      else                 w_end_cnt_nxt = r_end_cnt - 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_arm) begin
          w_end_tooth_nxt = i_end_tooth;
          w_end_cnt_nxt   = i_end_counts;
          if (i_start_counts == '0) begin
            w_fire_start = 1'b1;
          end else begin
            w_start_pend_nxt = 1'b1;
            w_start_cnt_nxt  = i_start_counts - 1'b1;
          end
          if (i_start_tooth == i_end_tooth) begin
            w_state_nxt = ST_WAIT_EXPIRY;
            if (i_end_counts == '0) begin
              w_fire_end = 1'b1;
            end else begin
              w_end_run_nxt = 1'b1;
              w_end_cnt_nxt = i_end_counts - 1'b1;
            end
          end else begin
            w_state_nxt = ST_WAIT_END_TOOTH;
          end
        end
      end
      ST_WAIT_END_TOOTH: begin
        if (w_end_match) begin
          w_state_nxt = ST_WAIT_EXPIRY;
          if (r_end_cnt == '0) begin
            w_fire_end = 1'b1;
          end else begin
            w_end_run_nxt = 1'b1;
            w_end_cnt_nxt = r_end_cnt - 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (w_fire_start) begin
      w_start_pend_nxt = 1'b0;
      w_active_nxt     = 1'b1;
    end

    // End expiry overrides a start firing in the same cycle: an early end
    // cancels the pulse entirely.
    if (w_fire_end) begin
      w_state_nxt      = ST_IDLE;
      w_start_pend_nxt = 1'b0;
      w_start_cnt_nxt  = '0;
      w_end_run_nxt    = 1'b0;
      w_end_cnt_nxt    = '0;
      w_active_nxt     = 1'b0;
      w_done_nxt       = 1'b1;
    end

`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
    if (r_active) begin
      if (r_on_cnt == ON_LIMIT) begin
        w_state_nxt      = ST_IDLE;
        w_start_pend_nxt = 1'b0;
        w_start_cnt_nxt  = '0;
        w_end_run_nxt    = 1'b0;
        w_end_cnt_nxt    = '0;
        w_active_nxt     = 1'b0;
        w_done_nxt       = 1'b1;
        w_fault_nxt      = 1'b1;
      end else begin
        w_on_cnt_nxt = r_on_cnt + 1'b1;
      end
    end
`endif

    // Loss of sync is a silent abort: no done pulse.
    if (i_sync_lost) begin
      w_state_nxt      = ST_IDLE;
      w_start_pend_nxt = 1'b0;
      w_start_cnt_nxt  = '0;
      w_end_run_nxt    = 1'b0;
      w_end_cnt_nxt    = '0;
      w_active_nxt     = 1'b0;
      w_done_nxt       = 1'b0;
`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
      w_on_cnt_nxt     = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_start_cnt  <= '0;
      r_start_pend <= 1'b0;
      r_end_cnt    <= '0;
      r_end_run    <= 1'b0;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
      r_on_cnt     <= '0;
      r_fault      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_start_cnt  <= w_start_cnt_nxt;
      r_start_pend <= w_start_pend_nxt;
      r_end_cnt    <= w_end_cnt_nxt;
      r_end_run    <= w_end_run_nxt;
      r_active     <= w_active_nxt;
      r_done       <= w_done_nxt;
`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
      r_on_cnt     <= w_on_cnt_nxt;
      r_fault      <= w_fault_nxt;
`endif
    end
    // Latched end tooth is only read in WAIT_END_TOOTH, which always follows
    // a load, so it needs no reset.
    r_end_tooth <= w_end_tooth_nxt;
  end

  assign o_out  = r_active ^ OUT_INVERT;
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;
`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_output_driver.sv
// -----------------------------------------------------------------------------
// multi_channel_output_driver
// NUM_CH independent tooth-scheduled output channels sharing one crank-position
// bus. Each channel asserts its output a programmed delay after its start tooth
// and deasserts it a programmed delay after its end tooth.
//
// Optional feature (macro MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN): per-channel
// overdwell limit of MAX_ON_COUNTS active cycles with sticky fault flag.
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   tooth_num     current tooth index
//   tooth_edge    one-cycle strobe, tooth_num valid
//   sync_lost     level; aborts all channels (no done pulse)
//   en            per-channel arm enable
//   start_tooth   packed, channel i at [i*TOOTH_W +: TOOTH_W]
//   end_tooth     packed, same layout
//   start_counts  packed, channel i at [i*TIMER_W +: TIMER_W]
//   end_counts    packed, same layout
//   out           channel outputs, polarity per OUT_INVERT
//   busy          channel not IDLE
//   done          one-cycle pulse on completed or cancelled event
//   fault         sticky overdwell flag
// -----------------------------------------------------------------------------
module multi_channel_output_driver
  import multi_channel_output_driver_pkg::*;
#(
  parameter int                 NUM_CH        = 4,
  parameter int                 TOOTH_W       = DEF_TOOTH_W,
  parameter int                 TIMER_W       = DEF_TIMER_W,
  parameter logic [NUM_CH-1:0]  OUT_INVERT    = {NUM_CH{1'b0}},
  parameter logic [TIMER_W-1:0] MAX_ON_COUNTS = {TIMER_W{1'b1}}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [TOOTH_W-1:0]          tooth_num,
  input  logic                        tooth_edge,
  input  logic                        sync_lost,
  input  logic [NUM_CH-1:0]           en,
  input  logic [NUM_CH*TOOTH_W-1:0]   start_tooth,
  input  logic [NUM_CH*TOOTH_W-1:0]   end_tooth,
  input  logic [NUM_CH*TIMER_W-1:0]   start_counts,
  input  logic [NUM_CH*TIMER_W-1:0]   end_counts,
  output logic [NUM_CH-1:0]           out,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           done,
  output logic [NUM_CH-1:0]           fault
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    output_driver_channel #(
      .TOOTH_W       (TOOTH_W),
      .TIMER_W       (TIMER_W),
      .OUT_INVERT    (OUT_INVERT[gi]),
      .MAX_ON_COUNTS (MAX_ON_COUNTS)
    ) u_ch (
      .clk            (clk),
      .i_reset        (reset),
      .i_tooth_num    (tooth_num),
      .i_tooth_edge   (tooth_edge),
      .i_sync_lost    (sync_lost),
      .i_en           (en[gi]),
      .i_start_tooth  (start_tooth[slice_lsb(gi, TOOTH_W) +: TOOTH_W]),
      .i_end_tooth    (end_tooth[slice_lsb(gi, TOOTH_W) +: TOOTH_W]),
      .i_start_counts (start_counts[slice_lsb(gi, TIMER_W) +: TIMER_W]),
      .i_end_counts   (end_counts[slice_lsb(gi, TIMER_W) +: TIMER_W]),
      .o_out          (out[gi]),
      .o_busy         (busy[gi]),
      .o_done         (done[gi]),
      .o_fault        (fault[gi])
    );
  end

endmodule

// File: tb/tb_multi_channel_output_driver.sv
module tb_multi_channel_output_driver;

  localparam int NCH = 4;
  localparam int TW  = 8;
  localparam int CW  = 24;
  localparam logic [NCH-1:0] INV = 4'b1000;
`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
  localparam logic [CW-1:0] MAXON = 24'd8;
`else
  localparam logic [CW-1:0] MAXON = 24'hFFFFFF;
`endif
  localparam int K_ON   = 0;
  localparam int K_OFF  = 1;
  localparam int K_DONE = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [TW-1:0]       tooth_num;
  logic                tooth_edge;
  logic                sync_lost;
  logic [NCH-1:0]      en;
  logic [NCH*TW-1:0]   start_tooth;
  logic [NCH*TW-1:0]   end_tooth;
  logic [NCH*CW-1:0]   start_counts;
  logic [NCH*CW-1:0]   end_counts;
  logic [NCH-1:0]      out;
  logic [NCH-1:0]      busy;
  logic [NCH-1:0]      done;
  logic [NCH-1:0]      fault;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit prev_on [NCH];

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  multi_channel_output_driver #(
    .NUM_CH        (NCH),
    .TOOTH_W       (TW),
    .TIMER_W       (CW),
    .OUT_INVERT    (INV),
    .MAX_ON_COUNTS (MAXON)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tooth_num    (tooth_num),
    .tooth_edge   (tooth_edge),
    .sync_lost    (sync_lost),
    .en           (en),
    .start_tooth  (start_tooth),
    .end_tooth    (end_tooth),
    .start_counts (start_counts),
    .end_counts   (end_counts),
    .out          (out),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_ON:    return "ON";
      K_OFF:   return "OFF";
      default: return "DONE";
    endcase
  endfunction

  task automatic push(input int ch, input int kind, input int at);
    ev_t e;
    e.ch = ch; e.kind = kind; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int ch, input int kind);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].ch == ch) begin
        idx = i;
        break;
      end
    end
    n_vec++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL ev_unexpected ch%0d: got %s at cyc %0d, expected no event", ch, kname(kind), cyc);
    end else begin
      if (exp_q[idx].kind != kind || exp_q[idx].cyc != cyc) begin
        n_bad++;
        $display("FAIL ev ch%0d: got %s at cyc %0d, expected %s at cyc %0d",
                 ch, kname(kind), cyc, kname(exp_q[idx].kind), exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output edge and done pulse is matched against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NCH; c++) begin
        bit act;
        act = (out[c] != INV[c]);
        if (act != prev_on[c]) begin
          check_event(c, act ? K_ON : K_OFF);
          prev_on[c] = act;
        end
        if (done[c]) check_event(c, K_DONE);
      end
    end
  end

  // Drives a one-cycle tooth strobe; must be called at a negedge.
  task automatic tooth(input logic [TW-1:0] n);
    tooth_num  = n;
    tooth_edge = 1'b1;
    @(negedge clk);
    tooth_edge = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e, s;
    logic [TW-1:0] wseq [8];
    wseq = '{8'd251, 8'd250, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};

    reset      = 1'b1;
    tooth_num  = '0;
    tooth_edge = 1'b0;
    sync_lost  = 1'b0;
    en         = '0;
`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
    start_tooth  = {8'd250, 8'd10, 8'd3, 8'd5};
    end_tooth    = {8'd2, 8'd10, 8'd4, 8'd6};
    start_counts = {24'd10, 24'd100, 24'd0, 24'd2};
    end_counts   = {24'd4, 24'd20, 24'd0, 24'd0};
`else
    start_tooth  = {8'd250, 8'd10, 8'd3, 8'd5};
    end_tooth    = {8'd2, 8'd10, 8'd4, 8'd5};
    start_counts = {24'd10, 24'd100, 24'd0, 24'd10};
    end_counts   = {24'd4, 24'd20, 24'd0, 24'd50};
`endif

    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_out",   out,   INV);
    chk("rst_busy",  busy,  4'b0000);
    chk("rst_done",  done,  4'b0000);
    chk("rst_fault", fault, 4'b0000);
    for (int c = 0; c < NCH; c++) prev_on[c] = 1'b0;
    mon_en = 1'b1;

`ifdef MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN
    // End tooth withheld: 8 active cycles then forced off with fault.
    en = 4'b0001;
    t = cyc;
    push(0, K_ON, t + 3);
    push(0, K_OFF, t + 11);
    push(0, K_DONE, t + 11);
    tooth(8'd5);
    idle(12);
    chk("ovd_fault_set", fault, 4'b0001);
    chk("ovd_busy", busy, 4'b0000);
    // Normal short event afterwards; fault stays sticky.
    t = cyc;
    push(0, K_ON, t + 3);
    tooth(8'd5);
    idle(3);
    e = cyc;
    push(0, K_OFF, e + 1);
    push(0, K_DONE, e + 1);
    tooth(8'd6);
    idle(3);
    chk("ovd_fault_sticky", fault, 4'b0001);
    mon_en = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("ovd_fault_cleared", fault, 4'b0000);
    chk("ovd_out_after_rst", out, INV);
    mon_en = 1'b1;
`else
    // A: ch0 equal teeth, 10/50.
    en = 4'b0001;
    t = cyc;
    push(0, K_ON, t + 11);
    push(0, K_OFF, t + 51);
    push(0, K_DONE, t + 51);
    tooth(8'd5);
    idle(3);
    chk("A_busy", busy, 4'b0001);
    idle(55);
    chk("A_busy_end", busy, 4'b0000);

    // B: ch1 start 3 / end 4, zero delays, then re-arm after done.
    en = 4'b1111;
    t = cyc;
    push(1, K_ON, t + 1);
    tooth(8'd3);
    idle(2);
    e = cyc;
    push(1, K_OFF, e + 1);
    push(1, K_DONE, e + 1);
    tooth(8'd4);
    idle(1);
    t = cyc;
    push(1, K_ON, t + 1);
    tooth(8'd3);
    idle(2);
    e = cyc;
    push(1, K_OFF, e + 1);
    push(1, K_DONE, e + 1);
    tooth(8'd4);
    idle(4);
    chk("B_busy_end", busy, 4'b0000);

    // C: ch2 early end (100 start vs 20 end): never active, done at T+21.
    en = 4'b0100;
    t = cyc;
    push(2, K_DONE, t + 21);
    tooth(8'd10);
    chk("C_busy", busy, 4'b0100);
    idle(25);
    chk("C_busy_end", busy, 4'b0000);
    chk("C_out_idle", out, INV);

    // D: ch3 inverted, start 250 end 2 across the wrap, duplicate start ignored.
    en = 4'b1000;
    t = cyc;
    push(3, K_ON, t + 11);
    tooth(8'd250);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      tooth(wseq[i]);
    end
    chk("D_out3_low", {31'd0, out[3]}, 32'd0);
    idle(1);
    e = cyc;
    push(3, K_OFF, e + 5);
    push(3, K_DONE, e + 5);
    tooth(8'd2);
    idle(8);
    chk("D_busy_end", busy, 4'b0000);

    // E: sync_lost mid-event on ch1 and ch3: both off next cycle, no done.
    en = 4'b1010;
    t = cyc;
    push(3, K_ON, t + 11);
    push(1, K_ON, t + 2);
    tooth(8'd250);
    tooth(8'd3);
    idle(15);
    s = cyc;
    push(1, K_OFF, s + 1);
    push(3, K_OFF, s + 1);
    sync_lost = 1'b1;
    idle(1);
    sync_lost = 1'b0;
    idle(3);
    chk("E_busy", busy, 4'b0000);
    chk("E_out", out, INV);
    chk("fault_tied", fault, 4'b0000);
`endif

    idle(5);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      foreach (exp_q[i])
        $display("FAIL ev_missing ch%0d: got nothing, expected %s at cyc %0d",
                 exp_q[i].ch, kname(exp_q[i].kind), exp_q[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_output_driver.md
Name: multi_channel_output_driver

Overview:
- Parametrised successor to the single-output tooth-scheduled driver: NUM_CH independent output channels (injectors/coils) share one crank-position bus.
- Each channel asserts its output a programmed delay after a start tooth and deasserts it a programmed delay after an end tooth.
- Internal down-counters replace external one-shots and latches. Adds per-channel polarity, sync-loss abort, a done pulse and early-end cancellation.

Parameters:
- NUM_CH, 4, number of output channels.
- TOOTH_W, 8, tooth index width.
- TIMER_W, 24, delay counter width in clk cycles.
- OUT_INVERT, {NUM_CH{1'b0}}, per-channel bit; 1 = active-low output.
- MAX_ON_COUNTS, 24'hFFFFFF, overdwell limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tooth_num  in  TOOTH_W  current tooth index
- tooth_edge  in  1  one-cycle strobe, tooth_num valid
- sync_lost  in  1  level; aborts all channels
- en  in  NUM_CH  per-channel arm enable
- start_tooth  in  NUM_CH*TOOTH_W  packed, channel i at [i*TOOTH_W +: TOOTH_W]
- end_tooth  in  NUM_CH*TOOTH_W  packed
- start_counts  in  NUM_CH*TIMER_W  packed
- end_counts  in  NUM_CH*TIMER_W  packed
- out  out  NUM_CH  channel outputs, polarity per OUT_INVERT
- busy  out  NUM_CH  channel not IDLE
- done  out  NUM_CH  one-cycle pulse on return to IDLE after a completed or cancelled event
- fault  out  NUM_CH  sticky overdwell flag

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset: all channels go to IDLE. out = OUT_INVERT (inactive); busy = 0, done = 0, fault = 0.
- Channels are fully independent. "Active" means out[i] = ~OUT_INVERT[i].
- States per channel: IDLE, WAIT_END_TOOTH, WAIT_EXPIRY.
- IDLE -> armed: on en[i] && tooth_edge && tooth_num == start_tooth[i] (call this cycle T):
  - latch end_tooth;
  - load start_cnt = start_counts and end_cnt = end_counts;
  - set start_pending.
- IDLE -> next state: if start_tooth == end_tooth, the end timer also starts at T and the channel goes to WAIT_EXPIRY. Otherwise it goes to WAIT_END_TOOTH.
- Start timer: decrements once per cycle while pending. Out goes active at cycle T+1+start_counts, so start_counts = 0 gives active at T+1.
- WAIT_END_TOOTH: on tooth_edge && tooth_num == end_tooth_latched (cycle E), the end timer starts and the channel goes to WAIT_EXPIRY. The start timer keeps running independently.
- End timer: out goes inactive at E+1+end_counts (or T+1+end_counts when start and end teeth are equal). The channel returns to IDLE in the same cycle and done pulses.
- Early end: if the end timer expires while start is still pending, including the same cycle, the end wins. Out never goes active; done still pulses.
- Arming: a channel can re-arm in the cycle after its done pulse. Start-tooth matches while busy are ignored. en is sampled only in IDLE; deasserting en mid-event does not abort.
- Tooth wrap: only equality is compared, so end_tooth < start_tooth (event spans cycle wrap) is legal.
- sync_lost = 1 at cycle S: every channel is IDLE with out inactive at S+1. No done pulse. Counters are cleared.
- Reset mid-event has the same effect as sync_lost and also clears fault.
- Counters are TIMER_W wide, unsigned, loaded directly and decremented to zero. They never wrap.

Optional Feature:
- MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN defined:
  - a per-channel on-time counter runs while out is active;
  - reaching MAX_ON_COUNTS forces out inactive next cycle and returns the channel to IDLE;
  - sets fault[i] (sticky until reset) and pulses done.
- Not defined: no on-time counter; fault is tied to 0; MAX_ON_COUNTS is ignored.

Decomposition:
- Shared package: channel state encoding (IDLE = 0, WAIT_END_TOOTH = 1, WAIT_EXPIRY = 2), TOOTH_W and TIMER_W defaults, and the packed-slice index helper.
- Sub-module output_driver_channel holds one channel's FSM, counters and polarity. The top is a generate loop plus slicing.

Test Plan:
- Ch0 start = 5, end = 5, start_counts = 10, end_counts = 50; edge on tooth 5 at T -> out0 active T+11..T+50, inactive at T+51, done0 pulse at T+51.
- Ch1 start = 3, end = 4, counts 0/0 -> out1 active at T3+1, inactive at E4+1; ch0, ch2 and ch3 are unaffected.
- Ch2 start = 10, end = 10, start_counts = 100, end_counts = 20 -> out2 never active, done2 at T+21.
- Ch3 OUT_INVERT = 1 -> out3 = 1 after reset, 0 during event. Assert sync_lost mid-event -> out3 = 1 next cycle, no done.
- Start = 250, end = 2 across wrap 255 -> 0 -> pulse spans wrap. A second start-tooth match while busy is ignored.
- With MULTI_CH_OUTPUT_DRIVER_OVERDWELL_EN and MAX_ON_COUNTS = 8, end tooth withheld -> out inactive after 8 active cycles, fault = 1 until reset.
